mem_arbiter: RTL and testbench

Single-port arbiter sequencing the shared cartridge-SDRAM access path between the GBA cartridge bus requester and the USB transfer requester. It grants one requester at a time and drives the `from_cart`/`from_usb` select strobes into `buffer`, which resolves the memory address and advances its segment offsets once per strobe. It then issues the access to the memory controller and returns completion (data/error) to the granted requester. Cart has fixed priority because it is real-time; USB is protected from starvation by a bounded loss counter.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter for the shared cartridge-SDRAM access path: the cart has fixed priority,
// and USB is forced to win after USB_STARVE_LIMIT consecutive lost arbitrations.
module mem_arbiter #(
  parameter int DATA_W           = 16,
  parameter int USB_STARVE_LIMIT = 8,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cart_req,
  input  logic              cart_we,
  input  logic [DATA_W-1:0] cart_wdata,
  output logic              cart_ack,
  output logic              cart_err,
  output logic [DATA_W-1:0] cart_rdata,
  input  logic              usb_req,
  input  logic              usb_we,
  input  logic [DATA_W-1:0] usb_wdata,
  output logic              usb_ack,
  output logic              usb_err,
  output logic [DATA_W-1:0] usb_rdata,
  output logic              from_cart,
  output logic              from_usb,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  localparam logic [7:0]  STARVE_MAX = 8'(USB_STARVE_LIMIT);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic                owner_usb_q, owner_usb_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          starve_q, starve_d;
  logic [15:0]         tmo_q, tmo_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   cart_rdata_q, cart_rdata_d;
  logic [DATA_W-1:0]   usb_rdata_q, usb_rdata_d;
  logic                grant_usb;

  // NOTE: every register here uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_usb_q  <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      starve_q     <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      cart_rdata_q <= '0;
      usb_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_usb_q  <= owner_usb_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      starve_q     <= starve_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      cart_rdata_q <= cart_rdata_d;
      usb_rdata_q  <= usb_rdata_d;
    end
  end

  // USB wins when the cart is idle or when USB has lost too many times in a row.
  assign grant_usb = usb_req && (!cart_req || (starve_q == STARVE_MAX));

  // NOTE: every _d signal gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_usb_d  = owner_usb_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    starve_d     = starve_q;
    tmo_d        = '0;
    err_d        = err_q;
    cart_rdata_d = cart_rdata_q;
    usb_rdata_d  = usb_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (!usb_req) starve_d = '0;
        if (mem_ready && (cart_req || usb_req)) begin
          owner_usb_d = grant_usb;
          we_d        = grant_usb ? usb_we    : cart_we;
          wdata_d     = grant_usb ? usb_wdata : cart_wdata;
          if (grant_usb) starve_d = '0;
          else if (usb_req && (starve_q != STARVE_MAX)) starve_d = starve_q + 8'd1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_done) begin
          err_d = 1'b0;
          if (owner_usb_q) usb_rdata_d = mem_rdata;
          else             cart_rdata_d = mem_rdata;
          state_d = S_ACK;
        end else if (tmo_q == TMO_LAST) begin
          err_d = 1'b1;
          if (owner_usb_q) usb_rdata_d = '1;
          else             cart_rdata_d = '1;
          state_d = S_ACK;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so there is no input-to-output path.
  always_comb begin
    mem_req    = (state_q == S_ISSUE);
    from_cart  = mem_req && !owner_usb_q;
    from_usb   = mem_req && owner_usb_q;
    mem_we     = mem_req && we_q;
    mem_wdata  = wdata_q;
    cart_ack   = (state_q == S_ACK) && !owner_usb_q;
    usb_ack    = (state_q == S_ACK) && owner_usb_q;
    cart_err   = cart_ack && err_q;
    usb_err    = usb_ack && err_q;
    cart_rdata = cart_rdata_q;
    usb_rdata  = usb_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level arbitration and memory model
// predicts each grant and each completion, and independent monitors compare them.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int L  = 8;
  localparam int T  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cart_req = 1'b0, cart_we = 1'b0;
  logic [DW-1:0] cart_wdata = '0;
  logic          usb_req = 1'b0, usb_we = 1'b0;
  logic [DW-1:0] usb_wdata = '0;
  logic          mem_ready = 1'b1, mem_done = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          cart_ack, cart_err, usb_ack, usb_err;
  logic          from_cart, from_usb, mem_req, mem_we;
  logic [DW-1:0] cart_rdata, usb_rdata, mem_wdata;

  mem_arbiter #(.DATA_W(DW), .USB_STARVE_LIMIT(L), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .cart_req(cart_req), .cart_we(cart_we), .cart_wdata(cart_wdata),
    .cart_ack(cart_ack), .cart_err(cart_err), .cart_rdata(cart_rdata),
    .usb_req(usb_req), .usb_we(usb_we), .usb_wdata(usb_wdata),
    .usb_ack(usb_ack), .usb_err(usb_err), .usb_rdata(usb_rdata),
    .from_cart(from_cart), .from_usb(from_usb),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            usb;
    bit            err;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            issue_cyc[$];
  bit            grant_log[$];
  int            n_checks = 0, n_fail = 0;
  int            cyc = 0;
  bit            c_s, u_s, r_s;
  int            losses = 0;
  bit            rand_lat = 1'b0, rand_phase = 1'b0;
  int            fix_k = 1;
  logic [DW-1:0] fix_data = '0;
  int            done_at = -1;
  logic [DW-1:0] done_data = '0;
  int            n_cart_ack = 0, n_usb_ack = 0;
  logic [DW-1:0] last_cart_rd = '0, last_usb_rd = '0;
  logic          last_we = 1'b0;
  logic [DW-1:0] last_wd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, 32'({cart_ack, cart_err, usb_ack, usb_err,
                                from_cart, from_usb, mem_req, mem_we}), 32'd0);
    check({name, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({name, "_cart_rdata"}, 32'(cart_rdata), 32'd0);
    check({name, "_usb_rdata"}, 32'(usb_rdata), 32'd0);
  endtask

  // Raise a request, hold it until its ack, then drop it in the ack cycle.
  task automatic do_access(input bit usb, input bit we, input logic [DW-1:0] wd,
                           output int ack_cyc);
    bit got;
    got = 1'b0;
    ack_cyc = -1;
    if (usb) begin usb_we = we; usb_wdata = wd; usb_req = 1'b1; end
    else     begin cart_we = we; cart_wdata = wd; cart_req = 1'b1; end
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (usb ? usb_ack : cart_ack) begin got = 1'b1; ack_cyc = cyc; end
    end
    if (usb) usb_req = 1'b0; else cart_req = 1'b0;
    check(usb ? "usb_ack_wait" : "cart_ack_wait", 32'(got), 32'd1);
  endtask

  task automatic run_agent(input bit usb, input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(3)) @(negedge clk);
      do_access(usb, 1'($urandom_range(1)), 16'($urandom), a);
      @(negedge clk);
    end
  endtask

  // Inputs as seen by the arbiter at each rising edge.
  initial forever begin
    @(posedge clk);
    c_s = cart_req;
    u_s = usb_req;
    r_s = mem_ready;
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rand_phase) mem_ready = ($urandom_range(3) != 0);
  end

  // Memory model plus grant predictor: pushes the expected completion at every issue.
  initial forever begin
    logic [1:0] exp_s;
    bit         win;
    int         k, r;
    exp_t       e;
    @(negedge clk);
    mem_done  = (cyc == done_at);
    mem_rdata = mem_done ? done_data : 16'($urandom);
    exp_s = 2'b00;
    if (mem_req) begin
      check("issue_has_req", 32'(c_s | u_s), 32'd1);
      check("issue_when_ready", 32'(r_s), 32'd1);
      win = u_s && (!c_s || losses == L);
      losses = (win || !u_s) ? 0 : losses + 1;
      exp_s = win ? 2'b01 : 2'b10;
      check("mem_we", 32'(mem_we), 32'(win ? usb_we : cart_we));
      check("mem_wdata", 32'(mem_wdata), 32'(win ? usb_wdata : cart_wdata));
      issue_cyc.push_back(cyc);
      grant_log.push_back(win);
      last_we = mem_we;
      last_wd = mem_wdata;
      if (rand_lat) begin
        r = $urandom_range(7);
        k = (r < 5) ? 1 + $urandom_range(2) : (r == 5) ? T : T + 1;
        done_data = 16'($urandom);
      end else begin
        k = fix_k;
        done_data = fix_data;
      end
      done_at = (k > 0) ? cyc + k : -1;
      e.usb = win;
      if (k >= 1 && k <= T) begin e.err = 1'b0; e.rdata = done_data; e.cyc = cyc + k + 1; end
      else                  begin e.err = 1'b1; e.rdata = '1;        e.cyc = cyc + 1 + T; end
      sb.push_back(e);
    end
    check("select_strobes", 32'({from_cart, from_usb}), 32'(exp_s));
  end

  // Completion monitor: pops the scoreboard whenever either requester is acked.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (cart_ack || usb_ack) begin
      check("ack_onehot", 32'(cart_ack & usb_ack), 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: cart_ack=%0b usb_ack=%0b with nothing outstanding (cycle %0d)",
                 cart_ack, usb_ack, cyc);
      end else begin
        e = sb.pop_front();
        check("ack_owner", 32'(usb_ack), 32'(e.usb));
        check("ack_cycle", cyc, e.cyc);
        if (e.usb) begin
          check("usb_err", 32'(usb_err), 32'(e.err));
          check("usb_rdata", 32'(usb_rdata), 32'(e.rdata));
          check("cart_rdata_hold", 32'(cart_rdata), 32'(last_cart_rd));
          last_usb_rd = e.rdata;
          n_usb_ack++;
        end else begin
          check("cart_err", 32'(cart_err), 32'(e.err));
          check("cart_rdata", 32'(cart_rdata), 32'(e.rdata));
          check("usb_rdata_hold", 32'(usb_rdata), 32'(last_usb_rd));
          last_cart_rd = e.rdata;
          n_cart_ack++;
        end
      end
    end
    check("err_without_ack", 32'((cart_err & ~cart_ack) | (usb_err & ~usb_ack)), 32'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, a, n0, cnt;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Single cart read with the fastest memory response.
    fix_k = 1; fix_data = 16'h1234; n0 = n_usb_ack; c0 = cyc;
    do_access(1'b0, 1'b0, 16'h0000, a);
    check("t1_issue_cycle", issue_cyc[$] - c0, 32'd1);
    check("t1_ack_cycle", a - c0, 32'd3);
    check("t1_cart_rdata", 32'(cart_rdata), 32'h1234);
    check("t1_cart_err", 32'(cart_err), 32'd0);
    check("t1_no_usb_ack", n_usb_ack - n0, 32'd0);
    @(negedge clk);

    // USB write held off by mem_ready.
    mem_ready = 1'b0; n0 = n_usb_ack;
    usb_we = 1'b1; usb_wdata = 16'hBEEF; usb_req = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t2_no_issue_while_busy", 32'(mem_req), 32'd0);
    end
    mem_ready = 1'b1;
    do_access(1'b1, 1'b1, 16'hBEEF, a);
    check("t2_mem_we", 32'(last_we), 32'd1);
    check("t2_mem_wdata", 32'(last_wd), 32'hBEEF);
    repeat (4) @(negedge clk);
    check("t2_single_usb_ack", n_usb_ack - n0, 32'd1);

    // Timeout with a late mem_done that must be ignored.
    fix_k = T + 3; fix_data = 16'h5555;
    do_access(1'b0, 1'b0, 16'h0000, a);
    check("t3_timeout_latency", a - (issue_cyc[$] + 1), T);
    check("t3_cart_err", 32'(cart_err), 32'd1);
    check("t3_cart_rdata", 32'(cart_rdata), 32'hFFFF);
    n0 = n_cart_ack;
    repeat (8) @(negedge clk);
    check("t3_late_done_ignored", n_cart_ack - n0, 32'd0);

    // Cart request held through the cycle after its ack is a second request.
    fix_k = 1; fix_data = 16'h0F0F; n0 = issue_cyc.size(); cnt = 0;
    cart_we = 1'b1; cart_wdata = 16'hA5A5; c0 = cyc; cart_req = 1'b1;
    for (int i = 0; i < 40 && cnt < 2; i++) begin
      @(negedge clk);
      if (cart_ack) cnt++;
    end
    cart_req = 1'b0;
    check("t4_two_acks", cnt, 32'd2);
    check("t4_two_issues", issue_cyc.size() - n0, 32'd2);
    if (issue_cyc.size() >= n0 + 2) begin
      check("t4_first_issue", issue_cyc[n0] - c0, 32'd1);
      check("t4_reissue", issue_cyc[n0 + 1] - c0, 32'd5);
    end
    repeat (3) @(negedge clk);

    // Reset in WAIT after a cart win over a pending USB request.
    fix_k = 0; cart_we = 1'b0; n0 = issue_cyc.size();
    cart_req = 1'b1; usb_req = 1'b1;
    for (int i = 0; i < 20 && issue_cyc.size() == n0; i++) @(negedge clk);
    check("t5_issued", issue_cyc.size() - n0, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_reset_in_wait");
    rst = 1'b0; cart_req = 1'b0; usb_req = 1'b0;
    sb.delete(); losses = 0; last_cart_rd = '0; last_usb_rd = '0;
    repeat (2) @(negedge clk);

    // Both requesting continuously: 8 cart grants then 1 USB, repeating.
    fix_k = 1; fix_data = 16'h3C3C; n0 = grant_log.size();
    cart_req = 1'b1; usb_req = 1'b1;
    for (int i = 0; i < 200 && grant_log.size() < n0 + 18; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cart_ack || usb_ack) break;
    end
    cart_req = 1'b0; usb_req = 1'b0;
    check("t6_grant_count", 32'(grant_log.size() >= n0 + 18), 32'd1);
    if (grant_log.size() >= n0 + 18)
      for (int i = 0; i < 18; i++)
        check($sformatf("t6_grant_%0d", i), 32'(grant_log[n0 + i]), 32'((i % 9) == 8));
    repeat (3) @(negedge clk);

    // Lone USB read after reset at minimum latency.
    fix_data = 16'h7E57; c0 = cyc;
    do_access(1'b1, 1'b0, 16'h0000, a);
    check("t7_usb_latency", a - c0, 32'd3);
    check("t7_usb_rdata", 32'(usb_rdata), 32'h7E57);
    @(negedge clk);

    // Randomized contention with random latency, timeouts and mem_ready gaps.
    rand_lat = 1'b1; rand_phase = 1'b1;
    fork
      run_agent(1'b0, 30);
      run_agent(1'b1, 30);
    join
    rand_phase = 1'b0; rand_lat = 1'b0; mem_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
